// File: rtl/mux_4x1_opselect_8bit_pkg.sv
// rtl/mux_4x1_opselect_8bit_pkg.sv - ALUOP codes and reset constants shared with the control unit
package alu_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SEL_W = 3;

  localparam logic [2:0] ALUOP_FWD = 3'b000;
  localparam logic [2:0] ALUOP_ADD = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;

  localparam logic [WIDTH-1:0] RESULT_RESET = 8'h00;

endpackage

// File: rtl/mux_4x1_opselect_8bit_if.sv
// rtl/mux_4x1_opselect_8bit_if.sv - operand, select and result bundle of the ALU result selector
interface mux_4x1_opselect_8bit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
);

  logic [WIDTH-1:0] FORWARD_RESULT;
  logic [WIDTH-1:0] ADD_RESULT;
  logic [WIDTH-1:0] AND_RESULT;
  logic [WIDTH-1:0] OR_RESULT;
  logic [SEL_W-1:0] SELECT;
  logic [WIDTH-1:0] RESULT;
  logic             SEL_INVALID;

  modport master (
    output FORWARD_RESULT, ADD_RESULT, AND_RESULT, OR_RESULT, SELECT,
    input  RESULT, SEL_INVALID
  );

  modport slave (
    input  FORWARD_RESULT, ADD_RESULT, AND_RESULT, OR_RESULT, SELECT,
    output RESULT, SEL_INVALID
  );

endinterface

// File: rtl/mux_4x1_opselect_8bit.sv
// rtl/mux_4x1_opselect_8bit.sv - registered 4:1 ALU result selector with reserved-code flag
module mux_4x1_opselect_8bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic CLK,
  input  logic RESET,
  mux_4x1_opselect_8bit_if.slave bus
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             invalid_d, invalid_q;

  // Reserved codes and any X/Z on SELECT fall through to the default arm.
  always_comb begin
    result_d  = WIDTH'(RESULT_RESET);
    invalid_d = 1'b1;
    case (bus.SELECT)
      SEL_W'(ALUOP_FWD): begin result_d = bus.FORWARD_RESULT; invalid_d = 1'b0; end
      SEL_W'(ALUOP_ADD): begin result_d = bus.ADD_RESULT;     invalid_d = 1'b0; end
      SEL_W'(ALUOP_AND): begin result_d = bus.AND_RESULT;     invalid_d = 1'b0; end
      SEL_W'(ALUOP_OR):  begin result_d = bus.OR_RESULT;      invalid_d = 1'b0; end
      default: begin
        result_d  = WIDTH'(RESULT_RESET);
        invalid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      result_q  <= WIDTH'(RESULT_RESET);
      invalid_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.RESULT      = result_q;
  assign bus.SEL_INVALID = invalid_q;

endmodule

// File: tb/tb_mux_4x1_opselect_8bit.sv
// tb/tb_mux_4x1_opselect_8bit.sv - directed and randomized checks of the ALU result selector
module tb_mux_4x1_opselect_8bit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mux_4x1_opselect_8bit_if #(.WIDTH(8), .SEL_W(3)) bus_if ();

  mux_4x1_opselect_8bit #(.WIDTH(8), .SEL_W(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pick(input int idx, input logic [7:0] f, input logic [7:0] a,
                                      input logic [7:0] n, input logic [7:0] o);
    logic [7:0] ops [4];
    ops[0] = f; ops[1] = a; ops[2] = n; ops[3] = o;
    return ops[idx];
  endfunction

  // Reference: what the outputs must hold one edge after the inputs were seen.
  logic [7:0] exp_res;
  logic       exp_inv;
  logic       model_valid;
  initial model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_res <= 8'h00;
      exp_inv <= 1'b0;
    end else if ($isunknown(bus_if.SELECT) || bus_if.SELECT > 3'd3) begin
      exp_res <= 8'h00;
      exp_inv <= 1'b1;
    end else begin
      exp_res <= pick(int'(bus_if.SELECT), bus_if.FORWARD_RESULT, bus_if.ADD_RESULT,
                      bus_if.AND_RESULT, bus_if.OR_RESULT);
      exp_inv <= 1'b0;
    end
    model_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check8("model_result", bus_if.RESULT, exp_res);
      check1("model_invalid", bus_if.SEL_INVALID, exp_inv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] f, input logic [7:0] a, input logic [7:0] n, input logic [7:0] o);
    bus_if.FORWARD_RESULT = f;
    bus_if.ADD_RESULT     = a;
    bus_if.AND_RESULT     = n;
    bus_if.OR_RESULT      = o;
  endtask

  logic [2:0] xsel;
  logic [7:0] lit_res [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    lit_res[0] = 8'h11; lit_res[1] = 8'h22; lit_res[2] = 8'h44; lit_res[3] = 8'h88;

    // Reset with all inputs high
    rst = 1'b1;
    set_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    bus_if.SELECT = 3'b001;
    for (int i = 0; i < 2; i++) begin
      tick();
      check8("reset_result", bus_if.RESULT, 8'h00);
      check1("reset_invalid", bus_if.SEL_INVALID, 1'b0);
    end
    rst = 1'b0;

    // Legal codes
    set_ops(8'h11, 8'h22, 8'h44, 8'h88);
    for (int s = 0; s < 4; s++) begin
      bus_if.SELECT = 3'(s);
      tick();
      check8("legal_result", bus_if.RESULT, lit_res[s]);
      check1("legal_invalid", bus_if.SEL_INVALID, 1'b0);
    end

    // Reserved codes, then recovery
    for (int s = 4; s < 8; s++) begin
      bus_if.SELECT = 3'(s);
      tick();
      check8("reserved_result", bus_if.RESULT, 8'h00);
      check1("reserved_invalid", bus_if.SEL_INVALID, 1'b1);
    end
    bus_if.SELECT = 3'b011;
    tick();
    check8("recover_result", bus_if.RESULT, 8'h88);
    check1("recover_invalid", bus_if.SEL_INVALID, 1'b0);

    // Unselected inputs must not leak through
    bus_if.SELECT = 3'b010;
    bus_if.AND_RESULT = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      bus_if.FORWARD_RESULT = 8'($urandom);
      bus_if.ADD_RESULT     = 8'($urandom);
      bus_if.OR_RESULT      = 8'($urandom);
      tick();
      check8("isolation_result", bus_if.RESULT, 8'h5A);
    end

    // Reset mid-stream
    bus_if.SELECT = 3'b001;
    bus_if.ADD_RESULT = 8'hC3;
    tick();
    check8("midrst_pre", bus_if.RESULT, 8'hC3);
    rst = 1'b1;
    tick();
    check8("midrst_clear", bus_if.RESULT, 8'h00);
    check1("midrst_invalid", bus_if.SEL_INVALID, 1'b0);
    rst = 1'b0;
    tick();
    check8("midrst_reload", bus_if.RESULT, 8'hC3);

    // Unknown select bits: a 4-state simulator sees X and must flag it;
    // a 2-state one collapses the X, and the select it ends up with decides.
    set_ops(8'h11, 8'h22, 8'h44, 8'h88);
    xsel = 3'bx10;
    bus_if.SELECT = xsel;
    tick();
    if ($isunknown(xsel)) begin
      check8("xsel_result", bus_if.RESULT, 8'h00);
      check1("xsel_invalid", bus_if.SEL_INVALID, 1'b1);
    end else begin
      check8("xsel_result", bus_if.RESULT, xsel[2] ? 8'h00 : lit_res[xsel[1:0]]);
      check1("xsel_invalid", bus_if.SEL_INVALID, xsel[2]);
    end

    // Randomized stream; the negedge compare process checks every cycle
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus_if.SELECT = 3'($urandom_range(0, 7));
      set_ops(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      tick();
    end
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
